// File: rtl/gecko_xor_pkg.sv
// gecko_xor_pkg
// Shared definitions for the gecko keystream decryptor: default buffer depth
// and counter width, plus the keystream fetch FSM state encoding.
package gecko_xor_pkg;

  localparam int KS_DEPTH_DEF  = 4;
  localparam int CNT_WIDTH_DEF = 16;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_GAP  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/gecko_ksbuf.sv
// gecko_ksbuf
// Circular byte buffer holding prefetched keystream bytes.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   clken         clock enable; pointers and storage hold while low
//   push/push_data  write one byte (ignored when full)
//   pop           drop the head byte (ignored when empty)
//   head          oldest buffered byte
//   full/empty    occupancy flags, from the registered pointers
module gecko_ksbuf #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clken,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [7:0]  r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty = (r_wr_ptr == r_rd_ptr);

  // Full is judged before any same-cycle pop, so a push into a full buffer
  // is dropped even if a slot frees up in that cycle.
  assign w_do_push = clken & push & ~full;
  assign w_do_pop  = clken & pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

  assign head = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/gecko_xor.sv
// gecko_xor
// Stream decryptor behind the gecko keystream generator. Prefetches keystream
// bytes into gecko_ksbuf and XORs each accepted ciphertext byte with the
// oldest buffered keystream byte, presenting plaintext on a registered
// valid/ready output.
// Ports:
//   clk, rst, clken          clock, sync active-high reset, shared clock enable
//   ks_ready, ks_byte        gecko byte available / gecko data
//   ks_next                  one-cycle request for the next gecko byte
//   din, din_valid, din_ready     ciphertext input handshake
//   dout, dout_valid, dout_ready  plaintext output handshake
//   byte_count               plaintext bytes delivered, wraps
//
// Fetch FSM
//   state  | meaning
//   F_IDLE | take ks_byte when gecko is ready and the buffer has room
//   F_GAP  | one idle cycle so gecko can drop ks_ready after ks_next
module gecko_xor
  import gecko_xor_pkg::*;
#(
  parameter int KS_DEPTH  = KS_DEPTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clken,
  input  logic                 ks_ready,
  input  logic [7:0]           ks_byte,
  output logic                 ks_next,
  input  logic [7:0]           din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [7:0]           dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [CNT_WIDTH-1:0] byte_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  fetch_state_t         r_state;
  logic [7:0]           r_dout;
  logic                 r_dout_valid;
  logic [CNT_WIDTH-1:0] r_byte_count;

  logic       w_full;
  logic       w_empty;
  logic [7:0] w_head;
  logic       w_push;
  logic       w_accept;
  logic       w_xfer;

  // ks_next must coincide with the push: gecko treats ready+next in the same
  // cycle as consumption of the byte it is presenting.
  assign w_push  = clken & ~rst & (r_state == F_IDLE) & ks_ready & ~w_full;
  assign ks_next = w_push;

  assign din_ready = clken & ~w_empty & (~r_dout_valid | dout_ready);
  assign w_accept  = din_valid & din_ready;
  assign w_xfer    = clken & r_dout_valid & dout_ready;

  gecko_ksbuf #(
    .DEPTH(KS_DEPTH)
  ) u_ksbuf (
    .clk      (clk),
    .rst      (rst),
    .clken    (clken),
    .push     (w_push),
    .push_data(ks_byte),
    .pop      (w_accept),
    .head     (w_head),
    .full     (w_full),
    .empty    (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= F_IDLE;
    end else if (clken) begin
      case (r_state)
        F_IDLE: if (w_push) r_state <= F_GAP;
        F_GAP:  r_state <= F_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= 8'h00;
      r_dout_valid <= 1'b0;
      r_byte_count <= '0;
    end else if (clken) begin
      if (w_accept) begin
        r_dout       <= din ^ w_head;
        r_dout_valid <= 1'b1;
      end else if (w_xfer) begin
        r_dout_valid <= 1'b0;
      end
      if (w_xfer) r_byte_count <= r_byte_count + CNT_ONE;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign byte_count = r_byte_count;

endmodule

// File: tb/tb_gecko_xor.sv
module tb_gecko_xor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clken = 1'b1;
  logic        ks_ready = 1'b0;
  logic [7:0]  ks_byte = 8'h00;
  logic        ks_next;
  logic [7:0]  din = 8'h00;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic [15:0] byte_count;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int g_mode = 0;          // 0: zero key, 1: keyed gecko model
  logic [7:0] exp_q[$];
  logic [7:0] key_tbl [2] = '{8'h3C, 8'hC3};

  gecko_xor #(.KS_DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .clken(clken),
    .ks_ready(ks_ready), .ks_byte(ks_byte), .ks_next(ks_next),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // gecko model: zero key keeps ready high with byte 0; keyed mode returns
  // the table bytes, each becoming ready 8 enabled cycles after the request.
  always begin : gecko_model
    logic nxt_seen, en_seen, rst_seen;
    int g_wait, g_idx;
    @(negedge clk);
    nxt_seen = ks_next; en_seen = clken; rst_seen = rst;
    @(posedge clk); #1;
    if (g_mode == 0) begin
      ks_ready = 1'b1; ks_byte = 8'h00;
    end else if (rst_seen) begin
      ks_ready = 1'b0; g_idx = 0; g_wait = 8;
    end else if (en_seen) begin
      if (ks_ready && nxt_seen) begin
        ks_ready = 1'b0; g_idx++; g_wait = 8;
      end else if (!ks_ready) begin
        if (g_wait > 1) g_wait--;
        else begin
          ks_ready = 1'b1; ks_byte = key_tbl[g_idx % 2];
        end
      end
    end
  end

  // Scoreboard monitor plus ks_next pulse-shape monitor.
  always begin : monitor
    logic prev_next;
    logic [7:0] e;
    @(negedge clk);
    if (!rst && clken && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", {24'h0, dout}, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("dout_data", {24'h0, dout}, {24'h0, e});
      end
    end
    if (ks_next) begin
      pulse_cnt++;
      chk("ks_next_width", {31'h0, prev_next}, 32'h0);
    end
    prev_next = ks_next;
  end

  task automatic reset_dut(input int mode);
    din_valid = 1'b0; clken = 1'b1; g_mode = mode; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; pulse_cnt = 0;
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] exp);
    int n = 0;
    exp_q.push_back(exp);
    din = c; din_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!din_ready && n < 60);
    if (!din_ready) begin
      chk("din_ready_timeout", 32'h0, 32'h1);
      din_valid = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
    chk("latency_valid", {31'h0, dout_valid}, 32'h1);
    chk("latency_dout", {24'h0, dout}, {24'h0, exp});
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int n;
    // Reset state (zero-key gecko holds ready high throughout)
    reset_dut(0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ks_next", {31'h0, ks_next}, 32'h0);
    chk("rst_dout", {24'h0, dout}, 32'h0);
    chk("rst_dout_valid", {31'h0, dout_valid}, 32'h0);
    chk("rst_byte_count", {16'h0, byte_count}, 32'h0);
    chk("rst_din_ready", {31'h0, din_ready}, 32'h0);

    // Zero key, back-to-back
    reset_dut(0);
    dout_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    send(8'hA5, 8'hA5);
    send(8'h3C, 8'h3C);
    send(8'hFF, 8'hFF);
    repeat (2) @(posedge clk);
    #1 chk("zero_key_count", {16'h0, byte_count}, 32'd3);

    // Keyed gecko model
    reset_dut(1);
    send(8'h5A, 8'h66);
    send(8'h5A, 8'h99);
    repeat (2) @(posedge clk);
    #1 chk("keyed_count", {16'h0, byte_count}, 32'd2);

    // Buffer full
    reset_dut(0);
    repeat (20) @(posedge clk);
    #1 chk("full_pulses", pulse_cnt, 32'd4);
    repeat (10) @(posedge clk);
    #1 chk("full_pulses_hold", pulse_cnt, 32'd4);
    send(8'h11, 8'h11);
    repeat (10) @(posedge clk);
    #1 chk("refill_pulse", pulse_cnt, 32'd5);

    // Backpressure
    reset_dut(0);
    dout_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    send(8'h66, 8'h66);
    din = 8'h12; din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_dout", {24'h0, dout}, 32'h66);
      chk("bp_valid", {31'h0, dout_valid}, 32'h1);
      chk("bp_din_ready", {31'h0, din_ready}, 32'h0);
    end
    exp_q.push_back(8'h12);
    @(posedge clk);
    #1 dout_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_din_ready", {31'h0, din_ready}, 32'h1);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    chk("bp_count", {16'h0, byte_count}, 32'd1);
    chk("bp_next_dout", {24'h0, dout}, 32'h12);
    repeat (2) @(posedge clk);
    #1 chk("bp_count_final", {16'h0, byte_count}, 32'd2);

    // clken stall mid-stream
    reset_dut(0);
    dout_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    send(8'h10, 8'h10);
    clken = 1'b0; din = 8'h20; din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ks_next", {31'h0, ks_next}, 32'h0);
      chk("stall_din_ready", {31'h0, din_ready}, 32'h0);
      @(posedge clk);
      #1;
      chk("stall_dout", {24'h0, dout}, 32'h10);
      chk("stall_valid", {31'h0, dout_valid}, 32'h1);
      chk("stall_count", {16'h0, byte_count}, 32'd0);
    end
    clken = 1'b1;
    send(8'h20, 8'h20);
    send(8'h30, 8'h30);
    repeat (2) @(posedge clk);
    #1 chk("stall_final_count", {16'h0, byte_count}, 32'd3);

    // Reset mid-operation
    reset_dut(0);
    dout_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1 din = 8'hAA; din_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!din_ready && n < 20);
    @(posedge clk);
    #1 din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("pre_rst_valid", {31'h0, dout_valid}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", {31'h0, dout_valid}, 32'h0);
    chk("mid_rst_dout", {24'h0, dout}, 32'h0);
    chk("mid_rst_count", {16'h0, byte_count}, 32'd0);
    chk("mid_rst_ks_next", {31'h0, ks_next}, 32'h0);
    chk("mid_rst_empty", {31'h0, din_ready}, 32'h0);
    rst = 1'b0;
    dout_ready = 1'b1;
    send(8'h77, 8'h77);
    repeat (2) @(posedge clk);
    #1 chk("post_rst_count", {16'h0, byte_count}, 32'd1);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(posedge clk); n++; end
    #1 chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gecko_xor.md
Name: gecko_xor

Overview:
Stream decryptor directly downstream of the gecko keystream generator. It prefetches keystream bytes from gecko into a small buffer using gecko's ready/next handshake. It XORs each accepted ciphertext byte with the oldest buffered keystream byte and presents plaintext on a registered valid/ready output. It sits between the encrypted byte source (boot/flash reader) and the plaintext consumer.

Parameters:
KS_DEPTH, 4, keystream buffer depth in bytes; power of two, >= 2
CNT_WIDTH, 16, width of the decrypted-byte counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active high
clken  input  1  clock enable, same enable that drives gecko; all state advances only when high
ks_ready  input  1  gecko ready: keystream byte valid on ks_byte
ks_byte  input  8  gecko dout
ks_next  output  1  one-cycle request to gecko for the next byte
din  input  8  ciphertext byte
din_valid  input  1  ciphertext byte present
din_ready  output  1  ciphertext byte accepted this cycle (combinational)
dout  output  8  plaintext byte
dout_valid  output  1  plaintext byte present
dout_ready  input  1  consumer accepts plaintext
byte_count  output  CNT_WIDTH  number of plaintext bytes delivered (dout_valid & dout_ready & clken)

Behaviour:
- Reset values: ks_next=0, dout=8'h00, dout_valid=0, byte_count=0; buffer empty; fetch FSM in F_IDLE. Only clk/rst/clken affect state; with clken=0, all registers hold and ks_next is forced to 0.
- Fetch FSM, states F_IDLE and F_GAP:
  - F_IDLE: if ks_ready and the buffer is not full, push ks_byte, assert ks_next for that cycle, and go to F_GAP.
  - F_GAP: ks_next=0 for exactly one clken cycle, giving gecko time to drop ready. Then return to F_IDLE.
  - Keyed gecko: about 10 clken cycles per byte. Zero key (ready stuck high, byte 0): one byte every 2 clken cycles; ks_next is pulsed but gecko ignores it.
- Buffer: circular, KS_DEPTH entries; read/write pointers one bit wider than the address for full/empty detection.
  - Simultaneous push and pop when full: the push is blocked (full is evaluated before the pop). Simultaneous push and pop when non-full: both occur and the count is unchanged.
- Data path:
  - din_ready = clken & buffer not empty & (!dout_valid | dout_ready).
  - On accept: dout <= din ^ buffer head, dout_valid <= 1, and the head is popped. Latency is 1 clken cycle from accept to dout_valid.
  - If dout_valid & dout_ready with no new accept, dout_valid <= 0 and dout holds its value.
  - dout and dout_valid are stable while dout_valid & !dout_ready.
- Throughput: 1 byte/cycle while the buffer holds data.
- byte_count increments on each output transfer and wraps modulo 2^CNT_WIDTH.
- Keystream order is strict: byte N of ciphertext is XORed with the Nth byte gecko produced after its reset. Keystream bytes are never discarded or reused.
- Reset mid-operation clears the buffer and the output register. The system resets gecko together with this block; resetting only one of them desynchronises the keystream and is not supported.
- din_valid without buffered keystream: din_ready=0, and the source holds the byte.

Decomposition:
- Shared package: KS_DEPTH and CNT_WIDTH defaults, fetch FSM state encodings (F_IDLE, F_GAP).
- Sub-module gecko_ksbuf: parameterised circular byte buffer with push/pop/full/empty and clken. The top level holds the fetch FSM, XOR output register and counter.

Test Plan:
- Zero key: ks_ready=1, ks_byte=8'h00 constant; din 8'hA5, 8'h3C, 8'hFF back-to-back -> dout 8'hA5, 8'h3C, 8'hFF, each one clken cycle after accept; byte_count=3.
- Keyed model: bench gecko model returns 8'h3C then 8'hC3, ready after 8 cycles; din 8'h5A, 8'h5A -> dout 8'h66, 8'h99. ks_next pulses are 1 cycle wide, separated by at least the F_GAP cycle.
- Buffer full: no din, ks_ready=1 -> exactly 4 ks_next pulses, then ks_next stays 0. One accepted din frees a slot -> exactly one more pulse.
- Backpressure: dout_ready=0 with dout_valid=1 and dout=8'h66 for 5 cycles -> dout unchanged, din_ready=0. Release -> transfer occurs and byte_count increments by 1.
- clken=0 for 3 cycles mid-transfer with din_valid=1 and ks_ready=1 -> no state change, ks_next=0, din_ready=0. Resume -> identical sequence to the unstalled run.
- rst asserted with 2 buffered bytes and dout_valid=1 -> next cycle dout_valid=0, dout=8'h00, byte_count=0, buffer empty, ks_next=0.
